// File: rtl/wisc_pkg.sv
// Shared WISC pipeline definitions: register-file geometry, opcodes and the
// hazard scoreboard slot record.
package wisc_pkg;

   localparam int unsigned REG_W    = 3;
   localparam int unsigned NUM_REGS = 8;

   // 5-bit major opcodes (instr[15:11])
   localparam logic [4:0] OP_HALT = 5'b00000;
   localparam logic [4:0] OP_NOP  = 5'b00001;
   localparam logic [4:0] OP_ADDI = 5'b01000;
   localparam logic [4:0] OP_SUBI = 5'b01001;
   localparam logic [4:0] OP_XORI = 5'b01010;
   localparam logic [4:0] OP_ANDN = 5'b01011;
   localparam logic [4:0] OP_ST   = 5'b10000;
   localparam logic [4:0] OP_LD   = 5'b10001;
   localparam logic [4:0] OP_LBI  = 5'b11000;
   localparam logic [4:0] OP_ALU  = 5'b11011;
   localparam logic [4:0] OP_BEQZ = 5'b01100;
   localparam logic [4:0] OP_J    = 5'b00100;
   localparam logic [4:0] OP_JAL  = 5'b00110;

   // One in-flight destination register
   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] wr_reg;
   } slot_t;

   // Source count 3 is not a real encoding; treat it like 2
   function automatic logic reads_rs(input logic [1:0] num_rd);
      return num_rd != 2'd0;
   endfunction

   function automatic logic reads_rt(input logic [1:0] num_rd);
      return num_rd[1];
   endfunction

endpackage

// File: rtl/stall_ctrl_if.sv
// ID-stage hazard bus between decode (master) and the stall controller (slave).
interface stall_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   import wisc_pkg::*;

   logic                 id_valid;
   logic [1:0]           id_num_rd;
   logic [REG_W-1:0]     id_rs;
   logic [REG_W-1:0]     id_rt;
   logic                 id_wr_en;
   logic [REG_W-1:0]     id_wr_reg;
   logic                 flush;

   logic                 stall;
   logic                 bubble;
   logic [NUM_REGS-1:0]  busy_vec;
   logic [CNT_W-1:0]     stall_cnt;

   modport master (
      output id_valid, id_num_rd, id_rs, id_rt, id_wr_en, id_wr_reg, flush,
      input  stall, bubble, busy_vec, stall_cnt
   );

   modport slave (
      input  id_valid, id_num_rd, id_rs, id_rt, id_wr_en, id_wr_reg, flush,
      output stall, bubble, busy_vec, stall_cnt
   );

endinterface

// File: rtl/sb_match.sv
// Compares one scoreboard slot against both ID source registers.
module sb_match
   import wisc_pkg::*;
(
   input  slot_t            slot,
   input  logic [REG_W-1:0] rs,
   input  logic [REG_W-1:0] rt,
   output logic             hit_s,
   output logic             hit_t
);

   // Register r0 is tracked like any other register
   always_comb begin
      hit_s = slot.valid & (slot.wr_reg == rs);
      hit_t = slot.valid & (slot.wr_reg == rt);
   end

endmodule

// File: rtl/stall_ctrl.sv
// Scoreboard RAW hazard controller for the forwarding-less WISC pipeline.
// Slot 0 mirrors ID/EX, the oldest slot mirrors MEM/WB.
module stall_ctrl
   import wisc_pkg::*;
#(
   parameter int unsigned DEPTH = 3,
   parameter int unsigned CNT_W = 16
) (
   input  logic         clk,
   input  logic         rst,
   stall_ctrl_if.slave  bus
);

   slot_t            slot_q [DEPTH];
   slot_t            ins_slot;
   logic [DEPTH-1:0] hit_s;
   logic [DEPTH-1:0] hit_t;
   logic             hazard;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [NUM_REGS-1:0] busy;

   for (genvar k = 0; k < DEPTH; k++) begin : g_match
      sb_match u_match (
         .slot  (slot_q[k]),
         .rs    (bus.id_rs),
         .rt    (bus.id_rt),
         .hit_s (hit_s[k]),
         .hit_t (hit_t[k])
      );
   end

   // Hazard detection; a flush squashes ID, so it never stalls
   always_comb begin
      hazard = bus.id_valid & ~bus.flush &
               ((reads_rs(bus.id_num_rd) & (|hit_s)) |
                (reads_rt(bus.id_num_rd) & (|hit_t)));
   end

   // Entry for the ID instruction that advances into ID/EX this edge
   always_comb begin
      ins_slot.valid  = bus.id_valid & bus.id_wr_en & ~hazard & ~bus.flush;
      ins_slot.wr_reg = bus.id_wr_reg;
   end

   // Per-register busy flags from all valid slots
   always_comb begin
      busy = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (slot_q[k].valid) begin
            busy[slot_q[k].wr_reg] = 1'b1;
         end
      end
   end

   // Saturating stall-cycle counter next state
   always_comb begin
      cnt_d = cnt_q;
      if (hazard && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Scoreboard shift; downstream never stalls so it shifts every edge
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            slot_q[k] <= '0;
         end
      end else begin
         slot_q[0] <= ins_slot;
         for (int k = 1; k < DEPTH; k++) begin
            slot_q[k] <= slot_q[k-1];
         end
      end
   end

   // Stall counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Outputs are combinational so decode sees them in the same cycle
   always_comb begin
      bus.stall     = hazard;
      bus.bubble    = hazard | (bus.flush & bus.id_valid);
      bus.busy_vec  = busy;
      bus.stall_cnt = cnt_q;
   end

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: directed scenarios plus random traffic
// against a writer-list reference model. A CNT_W=4 copy shares the stimulus to
// exercise counter saturation.
module tb_stall_ctrl;

   localparam int DEPTH = 3;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   stall_ctrl_if #(.CNT_W(16)) bus16 ();
   stall_ctrl_if #(.CNT_W(4))  bus4 ();

   stall_ctrl #(.DEPTH(DEPTH), .CNT_W(16)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus16)
   );

   stall_ctrl #(.DEPTH(DEPTH), .CNT_W(4)) u_dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Reference model: every accepted writer with the cycle it left ID.
   // It blocks readers for the DEPTH cycles following that cycle.
   typedef struct {
      int rg;
      int cyc;
   } wr_t;

   wr_t pend[$];
   int  cyc      = 0;
   int  exp_cnt16 = 0;
   int  exp_cnt4  = 0;
   bit  m_stall  = 0;

   logic        obs_stall;
   logic        obs_bubble;
   logic [7:0]  obs_busy;
   logic [15:0] obs_cnt16;
   logic [3:0]  obs_cnt4;

   function automatic bit reg_busy(input int r);
      foreach (pend[i]) begin
         if (pend[i].rg == r && (cyc - pend[i].cyc) >= 1 && (cyc - pend[i].cyc) <= DEPTH)
            return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic step(input bit v, input int nrd, input int rs, input int rt,
                       input bit we, input int wr, input bit fl, input bit r,
                       input bit chk);
      bit         hz;
      bit         bub;
      logic [7:0] ebusy;
      @(negedge clk);
      rst = r;
      bus16.id_valid  = v;         bus4.id_valid  = v;
      bus16.id_num_rd = 2'(nrd);   bus4.id_num_rd = 2'(nrd);
      bus16.id_rs     = 3'(rs);    bus4.id_rs     = 3'(rs);
      bus16.id_rt     = 3'(rt);    bus4.id_rt     = 3'(rt);
      bus16.id_wr_en  = we;        bus4.id_wr_en  = we;
      bus16.id_wr_reg = 3'(wr);    bus4.id_wr_reg = 3'(wr);
      bus16.flush     = fl;        bus4.flush     = fl;
      #1;
      hz  = v && !fl && ((nrd >= 1 && reg_busy(rs)) || (nrd >= 2 && reg_busy(rt)));
      bub = hz || (fl && v);
      for (int i = 0; i < 8; i++) ebusy[i] = reg_busy(i);
      obs_stall  = bus16.stall;
      obs_bubble = bus16.bubble;
      obs_busy   = bus16.busy_vec;
      obs_cnt16  = bus16.stall_cnt;
      obs_cnt4   = bus4.stall_cnt;
      if (chk) begin
         check_eq("stall",     {31'd0, obs_stall},  {31'd0, hz});
         check_eq("bubble",    {31'd0, obs_bubble}, {31'd0, bub});
         check_eq("busy_vec",  {24'd0, obs_busy},   {24'd0, ebusy});
         check_eq("stall_cnt", {16'd0, obs_cnt16},  exp_cnt16);
         check_eq("stall_cnt4", {28'd0, obs_cnt4},  exp_cnt4);
         check_eq("stall4",    {31'd0, bus4.stall}, {31'd0, hz});
      end
      if (r) begin
         pend.delete();
         exp_cnt16 = 0;
         exp_cnt4  = 0;
      end else begin
         if (hz && exp_cnt16 < 65535) exp_cnt16++;
         if (hz && exp_cnt4 < 15) exp_cnt4++;
         if (v && we && !hz && !fl) pend.push_back('{wr, cyc});
      end
      while (pend.size() > 0 && (cyc + 1 - pend[0].cyc) > DEPTH) void'(pend.pop_front());
      cyc++;
      m_stall = hz;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   initial begin
      int issued;
      int guard;
      int nrd, rs, rt, wr;
      bit v, we, fl, r;

      rst = 1'b1;
      // Reset: two cycles, state unknown before the first edge
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      check_eq("rst_stall",  {31'd0, obs_stall},  32'd0);
      check_eq("rst_bubble", {31'd0, obs_bubble}, 32'd0);
      check_eq("rst_busy",   {24'd0, obs_busy},   32'd0);
      check_eq("rst_cnt",    {16'd0, obs_cnt16},  32'd0);

      // Back-to-back dependence: ADDI r1 then ADD r?, r1, r3
      step(1, 1, 2, 0, 1, 1, 0, 0, 1);
      for (int i = 0; i < 4; i++) begin
         step(1, 2, 1, 3, 1, 4, 0, 0, 1);
         check_eq("b2b_stall", {31'd0, obs_stall}, {31'd0, (i < 3)});
         if (i < 3) check_eq("b2b_busy1", {31'd0, obs_busy[1]}, 32'd1);
         if (i == 3) check_eq("b2b_cnt", {16'd0, obs_cnt16}, 32'd3);
      end
      idle(4);

      // Source-count selection against a pending writer to r5
      step(1, 0, 0, 0, 1, 5, 0, 0, 1);
      step(1, 1, 2, 5, 0, 0, 0, 0, 1);
      check_eq("nrd1_rt_ignored", {31'd0, obs_stall}, 32'd0);
      step(1, 0, 5, 0, 0, 0, 0, 0, 1);
      check_eq("nrd0_never", {31'd0, obs_stall}, 32'd0);
      step(1, 2, 0, 5, 0, 0, 0, 0, 1);
      check_eq("nrd2_rt", {31'd0, obs_stall}, 32'd1);
      idle(4);

      // Flush beats stall and inserts nothing
      step(1, 0, 0, 0, 1, 4, 0, 0, 1);
      step(1, 1, 4, 0, 1, 6, 0, 0, 1);
      check_eq("fl_pre_stall", {31'd0, obs_stall}, 32'd1);
      step(1, 1, 4, 0, 1, 6, 1, 0, 1);
      check_eq("fl_stall",  {31'd0, obs_stall},  32'd0);
      check_eq("fl_bubble", {31'd0, obs_bubble}, 32'd1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      check_eq("fl_no_slot", {31'd0, obs_busy[6]}, 32'd0);
      check_eq("fl_r4_busy", {31'd0, obs_busy[4]}, 32'd1);
      idle(4);

      // Counter saturation: chain of 8 dependent writers to r2 -> 24 stalls
      step(0, 0, 0, 0, 0, 0, 0, 1, 1);
      step(1, 0, 0, 0, 1, 2, 0, 0, 1);
      issued = 0;
      guard  = 0;
      while (issued < 8 && guard < 200) begin
         step(1, 1, 2, 0, 1, 2, 0, 0, 1);
         if (!m_stall) issued++;
         guard++;
      end
      check_eq("sat_guard", guard < 200, 32'd1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      check_eq("sat_cnt16", {16'd0, obs_cnt16}, 32'd24);
      check_eq("sat_cnt4",  {28'd0, obs_cnt4},  32'd15);
      idle(4);

      // Reset in the middle of a stall
      step(1, 0, 0, 0, 1, 3, 0, 0, 1);
      step(1, 1, 3, 0, 0, 0, 0, 0, 1);
      step(1, 1, 3, 0, 0, 0, 0, 1, 1);
      check_eq("mid_rst_stall_before", {31'd0, obs_stall}, 32'd1);
      step(1, 1, 3, 0, 0, 0, 0, 0, 1);
      check_eq("mid_rst_stall", {31'd0, obs_stall}, 32'd0);
      check_eq("mid_rst_busy",  {24'd0, obs_busy},  32'd0);
      check_eq("mid_rst_cnt",   {16'd0, obs_cnt16}, 32'd0);

      // Random traffic; a stalled instruction is held in ID like real decode
      v = 0; nrd = 0; rs = 0; rt = 0; we = 0; wr = 0;
      for (int n = 0; n < 3000; n++) begin
         if (!m_stall) begin
            v   = ($urandom_range(0, 9) != 0);
            nrd = $urandom_range(0, 3);
            rs  = $urandom_range(0, 7);
            rt  = $urandom_range(0, 7);
            we  = ($urandom_range(0, 3) != 0);
            wr  = $urandom_range(0, 7);
         end
         fl = ($urandom_range(0, 11) == 0);
         r  = ($urandom_range(0, 79) == 0);
         step(v, nrd, rs, rt, we, wr, fl, r, 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
